// File: rtl/heartbeat_scanner.sv
// rtl/heartbeat_scanner.sv - bar-scanner heartbeat animator for NUM_DIGITS 7-segment digits
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   mode     2'b00 blank, 2'b01 bounce, 2'b10 wrap chase, 2'b11 freeze
//   restart  single-cycle pulse, restarts the animation from position 0
//   seg      registered active-low segments, digit d in seg[8d+7:8d] (dp,g,f,e,d,c,b,a)
//   step     registered one-cycle pulse on each position advance

module heartbeat_scanner #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 100000,
    parameter int STEP_TICKS = 80
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic                    restart,
    output logic [8*NUM_DIGITS-1:0] seg,
    output logic                    step
);

    localparam int PW  = $clog2(2 * NUM_DIGITS);
    localparam int PSW = $clog2(TICK_DIV);
    localparam int SW  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;

    localparam logic [PW-1:0]  POS_LAST   = PW'(2 * NUM_DIGITS - 1);
    localparam logic [PSW-1:0] PRESC_LAST = PSW'(TICK_DIV - 1);
    localparam logic [SW-1:0]  STC_LAST   = SW'(STEP_TICKS - 1);

    localparam logic [1:0] MODE_BLANK  = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_WRAP   = 2'b10;

    localparam logic [7:0] BAR_LEFT  = 8'b1100_1111;  // f,e lit
    localparam logic [7:0] BAR_RIGHT = 8'b1111_1001;  // c,b lit

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    logic [PSW-1:0]          presc_q, presc_d;
    logic [SW-1:0]           stc_q, stc_d;
    logic [PW-1:0]           pos_q, pos_d;
    dir_t                    dir_q, dir_d;
    logic [8*NUM_DIGITS-1:0] seg_d;
    logic                    step_d;

    logic running;
    logic tick;
    logic advance;

    // Only bounce and wrap let the timebase run; blank clears it, freeze holds it.
    assign running = (mode == MODE_BOUNCE) || (mode == MODE_WRAP);
    assign tick    = running && (presc_q == PRESC_LAST);
    assign advance = tick && (stc_q == STC_LAST);

    always_comb begin
        presc_d = presc_q;
        stc_d   = stc_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;

        if (running) begin
            presc_d = tick ? '0 : presc_q + PSW'(1);
            if (tick) begin
                stc_d = advance ? '0 : stc_q + SW'(1);
            end
        end

        // Wrap always chases upward, so a later switch to bounce continues up.
        if (mode == MODE_WRAP) begin
            dir_d = DIR_UP;
        end

        if (advance) begin
            step_d = 1'b1;
            if (mode == MODE_WRAP) begin
                pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
            end else if (dir_q == DIR_UP) begin
                if (pos_q == POS_LAST) begin
                    pos_d = POS_LAST - PW'(1);
                    dir_d = DIR_DOWN;
                end else begin
                    pos_d = pos_q + PW'(1);
                end
            end else begin
                if (pos_q == '0) begin
                    pos_d = PW'(1);
                    dir_d = DIR_UP;
                end else begin
                    pos_d = pos_q - PW'(1);
                end
            end
        end

        if (mode == MODE_BLANK || restart) begin
            presc_d = '0;
            stc_d   = '0;
            pos_d   = '0;
            dir_d   = DIR_UP;
            step_d  = 1'b0;
        end
    end

    // Segment image of the current position; position 0 is the leftmost bar.
    always_comb begin
        seg_d = '1;
        if (mode != MODE_BLANK) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                if (d == (NUM_DIGITS - 1) - int'(pos_q[PW-1:1])) begin
                    seg_d[8*d +: 8] = pos_q[0] ? BAR_RIGHT : BAR_LEFT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            stc_q   <= '0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
            seg     <= '1;
            step    <= 1'b0;
        end else begin
            presc_q <= presc_d;
            stc_q   <= stc_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            seg     <= seg_d;
            step    <= step_d;
        end
    end

endmodule

// File: tb/tb_heartbeat_scanner.sv
// tb/tb_heartbeat_scanner.sv - scoreboard bench for heartbeat_scanner (2 digits, 6-cycle step)

module tb_heartbeat_scanner;

    localparam int N  = 2;
    localparam int TD = 2;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic          restart;
    logic [8*N-1:0] seg;
    logic          step;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ref_cyc  = 0;

    typedef struct {
        logic [15:0] seg;
        int          gap;
    } exp_t;

    exp_t sb[$];

    heartbeat_scanner #(
        .NUM_DIGITS(N),
        .TICK_DIV  (TD),
        .STEP_TICKS(ST)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mode   (mode),
        .restart(restart),
        .seg    (seg),
        .step   (step)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] s, input int g);
        exp_t e;
        e.seg = s;
        e.gap = g;
        sb.push_back(e);
    endtask

    // Pop one expectation per step pulse: gap since reference, then seg a cycle later.
    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            int   waited;
            e      = sb.pop_front();
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!step && waited < 40);
            check("step_seen", step, 1);
            check("step_gap", cyc - ref_cyc, e.gap);
            ref_cyc = cyc;
            @(negedge clk);
            check("step_seg", seg, e.seg);
        end
    endtask

    task automatic window(input int n, input logic [15:0] exp_seg, output int steps, output int bad);
        steps = 0;
        bad   = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (step) steps++;
            if (seg !== exp_seg) bad++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int steps;
        int bad;

        reset   = 1'b1;
        mode    = 2'b00;
        restart = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_seg", seg, 16'hFFFF);
        check("reset_step", step, 0);
        reset = 1'b0;

        window(20, 16'hFFFF, steps, bad);
        check("blank_steps", steps, 0);
        check("blank_seg_bad", bad, 0);

        // Mid-run asynchronous reset in bounce.
        mode = 2'b01;
        repeat (8) @(negedge clk);
        #2 reset = 1'b1;
        #1 check("async_rst_seg", seg, 16'hFFFF);
        check("async_rst_step", step, 0);
        @(negedge clk);
        reset   = 1'b0;
        ref_cyc = cyc;
        @(negedge clk);
        check("bounce_p0", seg, 16'hCFFF);

        push(16'hF9FF, 6); push(16'hFFCF, 6); push(16'hFFF9, 6); push(16'hFFCF, 6);
        push(16'hF9FF, 6); push(16'hCFFF, 6); push(16'hF9FF, 6);
        observe(7);

        // Restart on the cycle an advance is due (p=1).
        repeat (4) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("restart_no_step", step, 0);
        ref_cyc = cyc;
        @(negedge clk);
        check("restart_seg", seg, 16'hCFFF);
        push(16'hF9FF, 6);
        observe(1);

        // Reach p=2, freeze for 30 cycles, resume at residual count.
        push(16'hFFCF, 6);
        observe(1);
        mode = 2'b11;
        window(30, 16'hFFCF, steps, bad);
        check("freeze_steps", steps, 0);
        check("freeze_seg_bad", bad, 0);
        mode    = 2'b01;
        ref_cyc = cyc;
        push(16'hFFF9, 5);
        observe(1);

        // Wrap chase from p=0.
        mode    = 2'b10;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        ref_cyc = cyc;
        @(negedge clk);
        check("wrap_p0", seg, 16'hCFFF);
        push(16'hF9FF, 6); push(16'hFFCF, 6); push(16'hFFF9, 6); push(16'hCFFF, 6);
        push(16'hF9FF, 6); push(16'hFFCF, 6); push(16'hFFF9, 6);
        observe(7);

        // Wrap at p=3 into bounce: continues up, so turns down.
        mode = 2'b01;
        push(16'hFFCF, 6); push(16'hF9FF, 6);
        observe(2);

        // Blank mid-period, then bounce: full period from p=0.
        repeat (2) @(negedge clk);
        mode = 2'b00;
        repeat (4) @(negedge clk);
        check("blank_again_seg", seg, 16'hFFFF);
        mode    = 2'b01;
        ref_cyc = cyc;
        @(negedge clk);
        check("unblank_p0", seg, 16'hCFFF);
        push(16'hF9FF, 6);
        observe(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/heartbeat_scanner.md
Name: heartbeat_scanner

Overview:
- Parametrised successor to the board's fixed four-digit heartbeat animator.
- Drives NUM_DIGITS active-low 7-segment digit patterns in one of four run-time modes: blank, bounce scanner, one-way wrap chase, or freeze.
- The animation rate is parametrised.
- Sits between the system clock/reset and the seven-segment multiplexer; consumes no bus and needs no software setup.

Parameters:
- NUM_DIGITS, 4, number of digits driven; legal range 2 to 16.
- TICK_DIV, 100000, system clocks per prescaler tick; 1 ms at 100 MHz; must be 2 or more.
- STEP_TICKS, 80, prescaler ticks per animation step; must be 1 or more.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mode  input  2  animation mode: 00 blank, 01 bounce, 10 wrap, 11 freeze.
- restart  input  1  synchronous, single-cycle pulse: restarts the animation from position 0.
- seg  output  8*NUM_DIGITS  registered segment vector. Digit d occupies seg[8d+7:8d]. Bit order per digit is dp,g,f,e,d,c,b,a (bit7 to bit0). Active low.
- step  output  1  registered one-cycle pulse on each position advance.

Behaviour:
- Reset (asynchronous, active-high, one clock, per the decided interface) sets:
  - prescaler = 0, step counter = 0, position = 0, direction = up;
  - seg = all ones (blank); step = 0.
  - Reset asserted mid-animation takes effect immediately, with no partial step.
- Prescaler counts 0..TICK_DIV-1. A tick occurs on the cycle where count == TICK_DIV-1; the counter then wraps to 0.
- Step counter increments on each tick, over 0..STEP_TICKS-1. An advance occurs on a tick where step count == STEP_TICKS-1; the counter then wraps to 0.
  - Step period is TICK_DIV*STEP_TICKS cycles exactly.
- Position width is clog2(2*NUM_DIGITS); there are 2*NUM_DIGITS bar positions.
- Position p maps to digit NUM_DIGITS-1-(p>>1).
  - p even: left bar lit (f,e); that digit = 8'b1100_1111.
  - p odd: right bar lit (c,b); that digit = 8'b1111_1001.
  - All other digits = 8'hFF.
- mode 00 (blank):
  - Prescaler and step counter held at 0; position = 0; direction = up.
  - seg = all ones; no step pulses.
- mode 01 (bounce), on each advance:
  - dir up and p < 2N-1: p+1.
  - dir up and p == 2N-1: p becomes 2N-2, dir becomes down.
  - dir down and p > 0: p-1.
  - dir down and p == 0: p becomes 1, dir becomes up.
  - Endpoints are never repeated on consecutive steps.
- mode 10 (wrap), on each advance:
  - p == 2N-1: p becomes 0; otherwise p+1.
  - dir is forced to up every cycle in this mode.
- mode 11 (freeze):
  - Prescaler, step counter, position and dir all hold.
  - seg keeps showing the current bar; no step pulses.
- Mode changes between 01, 10 and 11 preserve the prescaler, step counter and position; no restart occurs.
  - Leaving 10 for 01 continues upward.
  - Leaving 00 for any mode starts from p=0 with a full step period before the first advance.
- restart: in the cycle after the pulse, prescaler = 0, step counter = 0, p = 0, dir = up, in any mode.
  - restart has priority over an advance in the same cycle, and over the mode's hold/clear behaviour.
- step goes high in the cycle after the advance condition; the position register updates on the same edge.
- seg is registered from the current position and mode. It reflects a new position one cycle after step rises.
  - Latency from a mode change to seg is one cycle.

Test Plan (NUM_DIGITS=2, TICK_DIV=2, STEP_TICKS=3, so a 6-cycle step period):
- Reset, then mode=00 for 20 cycles.
  - Required: seg = 16'hFFFF throughout; step never asserts.
  - Then assert reset mid-run in mode 01: seg becomes 16'hFFFF at once, p = 0.
- mode=01 from reset.
  - Required: step fires every 6 cycles.
  - seg sequence: CFFF (p0), F9FF, FFCF, FFF9, FFCF, F9FF, CFFF, F9FF.
  - Bounce confirmed with no endpoint repeated.
- mode=10.
  - Required: seg sequence CFFF, F9FF, FFCF, FFF9, CFFF; wrap at p=3 goes to 0.
- mode=01 until p=2, then mode=11 for 30 cycles, then mode=01.
  - Required: seg holds FFCF with no step pulses during freeze.
  - Next advance occurs at the residual count, i.e. the remaining cycles of the interrupted period, not a full 6.
- restart pulsed on the exact cycle an advance is due (p=1).
  - Required: no advance; p = 0 and seg = CFFF.
  - Next step occurs exactly 6 cycles later.
- mode=10 until p=3, then switch to mode=01.
  - Required: next steps go p=2, then p=1 (dir up at the 3 boundary turns down).
- mode=00 to mode=01 mid-period.
  - Required: first step occurs 6 cycles after the switch.
